pel_delay_sub: RTL and testbench
================================

Name: pel_delay_sub

Overview:
- Multi-flux dataflow actor sitting directly downstream of the per-flux one-token pel delay stage in the HEVC 8-pixel path.
- Consumes, per flux, the current pel stream and the delayed pel stream produced by the delay stage.
- Emits a tagged signed residual: current minus delayed.
- A per-flux position counter marks the first pel of each block of BLOCK_LEN pels. For that pel the raw pel is forwarded instead of a residual, so every block restarts from an absolute value.

Parameters:
- FLUX, 2, number of independent interleaved data fluxes (tag space).
- DATA_WIDTH, 18, unsigned pel width on both inputs.
- BLOCK_LEN, 8, pels per block per flux; must be ≥2.
- TAG_WIDTH, $clog2(FLUX), tag width (derived, local).
- CNT_WIDTH, $clog2(BLOCK_LEN), per-flux counter width (derived, local).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- read_port_in_pel  read_interface.actor  dout TAG_WIDTH+DATA_WIDTH, empty/read FLUX  current pel FIFO bank.
- read_port_in_del  read_interface.actor  dout TAG_WIDTH+DATA_WIDTH, empty/read FLUX  delayed pel FIFO bank.
- write_port_out_res  write_interface.actor  din TAG_WIDTH+DATA_WIDTH+1, full FLUX, write 1  residual FIFO bank.

Behaviour:
- Fire condition for flux f: in_pel.empty[f]==0, in_del.empty[f]==0, out_res.full[f]==0, and rst high.
- Arbitration is fixed priority: the lowest-index eligible f wins. At most one firing per cycle.
- Firing is combinational, zero-latency FIFO-handshake style, in the same cycle as eligibility:
  - in_pel.read[f]=1 and in_del.read[f]=1.
  - All other read bits are 0.
  - out_res.write=1, out_res.din={f, result}.
  - Both inputs are always consumed together; one is never read without the other.
- No firing: all read bits 0, write=0, din don't-care (drive 'x).
- While rst is low: reads and write forced to 0.
- Per-flux state cnt[f] (CNT_WIDTH bits), reset to 0 asynchronously.
  - On a firing of f, cnt[f] increments, wrapping BLOCK_LEN-1 -> 0.
  - Counters of non-firing fluxes hold.
- Result (DATA_WIDTH+1 bits, two's complement):
  - cnt[f]==0: zero-extended pel. The delayed token is still consumed and discarded.
  - otherwise: sign-extended (pel - del), computed at DATA_WIDTH+1 bits; cannot overflow.
- Input tag bits of dout are ignored; the flux index comes from the FIFO bank position.
- Reset asserted mid-stream: all counters return to 0 immediately and outputs deassert. The first post-reset firing of each flux is a block start.
- Back-pressure on flux f (full[f]=1) stalls only f; other fluxes proceed.
- Simultaneous eligibility of several fluxes: the lower index fires this cycle, the others next eligible cycle(s).

Optional Feature:
- Macro: PEL_DELAY_SUB_SAT_EN.
- Defined: non-block-start residuals are clamped to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], then sign-extended to DATA_WIDTH+1 bits. Block-start passthrough values are not clamped.
- Undefined: full-range unclamped residual as above.
- Handshake and timing are identical in both builds.

Test Plan:
- Reset, flux0 pel=100/del=0, then pel=105/del=100 -> out din {0, 100} then {0, 5}; cnt[0]=2.
- Flux1 nine firings with BLOCK_LEN=8 and pel=50 del=60 each -> outputs 50, then seven of -10 (0x7FFF6 at 19 bits), then 50 again at the 9th (wrap).
- Both fluxes eligible same cycle -> flux0 fires first, flux1 fires next cycle; read bits never both high.
- out_res.full[0]=1 with flux0 data available and flux1 eligible -> flux1 fires, flux0 reads stay 0 and cnt[0] holds; full[0] deasserted -> flux0 fires.
- in_del.empty[0]=1 with in_pel nonempty -> no read on either port for flux0, write=0.
- pel=0, del=262143 mid-block:
  - without macro -> -262143 (0x40001).
  - with PEL_DELAY_SUB_SAT_EN -> -131072 (0x60000).
  - Asserting rst mid-block then a firing -> raw pel passthrough.

Source files
------------

// File: rtl/pel_delay_sub_if.sv
// FIFO-bank interfaces used by pel_delay_sub.
//   read_interface  : one FIFO per flux; dout[f] is the head word of FIFO f.
//   write_interface : one output FIFO bank; the tag in din selects the FIFO.
//
// Handshake: zero-latency FIFO style. A flux is "valid" when empty[f]==0;
// the actor consumes the head word by raising read[f] in the same cycle it
// looks at dout[f]. The output side is "ready" when full[f]==0; a word is
// pushed whenever write==1 at the rising clock edge.
interface read_interface #(
  parameter int FLUX  = 2,
  parameter int WIDTH = 19
);
  logic [FLUX-1:0][WIDTH-1:0] dout;
  logic [FLUX-1:0]            empty;
  logic [FLUX-1:0]            read;

  modport actor (input dout, input empty, output read);
  modport fifo  (output dout, output empty, input read);
endinterface

interface write_interface #(
  parameter int FLUX  = 2,
  parameter int WIDTH = 20
);
  logic [WIDTH-1:0] din;
  logic [FLUX-1:0]  full;
  logic             write;

  modport actor (output din, output write, input full);
  modport fifo  (input din, input write, output full);
endinterface

// File: rtl/pel_delay_sub.sv
// pel_delay_sub: multi-flux actor emitting current-minus-delayed pel
// residuals. The first pel of every BLOCK_LEN block of a flux is forwarded
// raw so each block restarts from an absolute value.
// Optional build macro PEL_DELAY_SUB_SAT_EN clamps non-block-start residuals
// to the signed DATA_WIDTH range; handshake and timing are unchanged.
module pel_delay_sub #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 18,
  parameter int BLOCK_LEN  = 8
) (
  input  logic          clk,
  input  logic          rst,
  read_interface.actor  read_port_in_pel,
  read_interface.actor  read_port_in_del,
  write_interface.actor write_port_out_res
);
  localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1;
  localparam int CNT_WIDTH = $clog2(BLOCK_LEN);
  localparam int RES_WIDTH = DATA_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(BLOCK_LEN - 1);

  logic [CNT_WIDTH-1:0] cnt [FLUX];
  logic [FLUX-1:0]      eligible;
  logic [FLUX-1:0]      grant;
  logic                 fire;
  logic [TAG_WIDTH-1:0] sel;
  logic [DATA_WIDTH-1:0] pel;
  logic [DATA_WIDTH-1:0] del;
  logic [RES_WIDTH-1:0]  diff;
  logic [RES_WIDTH-1:0]  residual;
  logic [RES_WIDTH-1:0]  result;
  logic                  block_start;
  logic                  unused_tag_bits;

  // A flux may fire only with both input tokens present, output room, and reset released.
  assign eligible = ~read_port_in_pel.empty & ~read_port_in_del.empty
                  & ~write_port_out_res.full & {FLUX{rst}};

  // Fixed-priority arbiter: lowest eligible flux index wins, one firing per cycle.
  always_comb begin
    fire  = 1'b0;
    sel   = '0;
    grant = '0;
    for (int f = 0; f < FLUX; f++) begin
      if (eligible[f] && !fire) begin
        fire     = 1'b1;
        sel      = TAG_WIDTH'(f);
        grant[f] = 1'b1;
      end
    end
  end

  // Residual datapath for the selected flux; incoming tag bits are ignored.
  always_comb begin
    pel         = read_port_in_pel.dout[sel][DATA_WIDTH-1:0];
    del         = read_port_in_del.dout[sel][DATA_WIDTH-1:0];
    diff        = {1'b0, pel} - {1'b0, del};
    block_start = (cnt[sel] == '0);
`ifdef PEL_DELAY_SUB_SAT_EN
    // Clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; diff itself never wraps.
    if ($signed(diff) > $signed({2'b00, {(DATA_WIDTH-1){1'b1}}})) begin
      residual = {2'b00, {(DATA_WIDTH-1){1'b1}}};
    end else if ($signed(diff) < $signed({2'b11, {(DATA_WIDTH-1){1'b0}}})) begin
      residual = {2'b11, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      residual = diff;
    end
`else
    residual = diff;
`endif
    result = block_start ? {1'b0, pel} : residual;
  end

  // Tag bits of the input words carry no information here.
  assign unused_tag_bits = ^{read_port_in_pel.dout[sel][TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH],
                             read_port_in_del.dout[sel][TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH]};

  // Both input tokens of the winning flux are consumed together with the output push.
  assign read_port_in_pel.read   = grant;
  assign read_port_in_del.read   = grant;
  assign write_port_out_res.write = fire;
  assign write_port_out_res.din   = fire ? {sel, result} : {(TAG_WIDTH+RES_WIDTH){1'bx}};

  // Per-flux block position counters; only the firing flux advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < FLUX; f++) begin
        cnt[f] <= '0;
      end
    end else if (fire) begin
      cnt[sel] <= (cnt[sel] == CNT_LAST) ? '0 : cnt[sel] + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_pel_delay_sub.sv
// Testbench for pel_delay_sub: software FIFO banks feed the DUT; a
// behavioural model (firing count modulo block length, integer arithmetic)
// predicts every handshake bit and output word.
module tb_pel_delay_sub;
  localparam int FLUX  = 2;
  localparam int DW    = 18;
  localparam int BL    = 8;
  localparam int TW    = 1;
  localparam int OW    = TW + DW + 1;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  read_interface  #(.FLUX(FLUX), .WIDTH(TW+DW)) pel_if ();
  read_interface  #(.FLUX(FLUX), .WIDTH(TW+DW)) del_if ();
  write_interface #(.FLUX(FLUX), .WIDTH(OW))    res_if ();

  pel_delay_sub #(.FLUX(FLUX), .DATA_WIDTH(DW), .BLOCK_LEN(BL)) dut (
    .clk               (clk),
    .rst               (rst_n),
    .read_port_in_pel  (pel_if),
    .read_port_in_del  (del_if),
    .write_port_out_res(res_if)
  );

  int errors = 0;
  int checks = 0;

  // software FIFO banks
  logic [DW-1:0] pel_mem [FLUX][DEPTH];
  logic [DW-1:0] del_mem [FLUX][DEPTH];
  int pel_wr [FLUX];
  int pel_rd [FLUX];
  int del_wr [FLUX];
  int del_rd [FLUX];
  logic [FLUX-1:0] full_bits;

  // reference model state: firings since last reset, per flux
  int fires [FLUX];
  logic [OW-1:0] exp_q [$];
  logic [OW-1:0] got_q [$];
  logic [FLUX-1:0] last_rd;
  logic last_wr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int f, input bit do_pel, input logic [DW-1:0] p,
                      input bit do_del, input logic [DW-1:0] d);
    if (do_pel) begin pel_mem[f][pel_wr[f] % DEPTH] = p; pel_wr[f]++; end
    if (do_del) begin del_mem[f][del_wr[f] % DEPTH] = d; del_wr[f]++; end
  endtask

  task automatic drive();
    for (int f = 0; f < FLUX; f++) begin
      pel_if.empty[f] = (pel_rd[f] == pel_wr[f]);
      del_if.empty[f] = (del_rd[f] == del_wr[f]);
      pel_if.dout[f]  = {TW'($urandom_range(0, 1)), pel_mem[f][pel_rd[f] % DEPTH]};
      del_if.dout[f]  = {TW'($urandom_range(0, 1)), del_mem[f][del_rd[f] % DEPTH]};
      res_if.full[f]  = full_bits[f];
    end
  endtask

  function automatic logic [DW:0] model_value(input int f);
    int p;
    int d;
    int r;
    logic signed [31:0] rv;
    p = int'(pel_mem[f][pel_rd[f] % DEPTH]);
    d = int'(del_mem[f][del_rd[f] % DEPTH]);
    if (fires[f] % BL == 0) begin
      r = p;
    end else begin
      r = p - d;
`ifdef PEL_DELAY_SUB_SAT_EN
      if (r > (1 << (DW-1)) - 1) r = (1 << (DW-1)) - 1;
      if (r < -(1 << (DW-1)))    r = -(1 << (DW-1));
`endif
    end
    rv = r;
    return rv[DW:0];
  endfunction

  // One clock: drive, compare against model at negedge, then advance model.
  task automatic cycle();
    bit exp_fire;
    int exp_f;
    logic [FLUX-1:0] exp_rd;
    logic [31:0] fv;
    drive();
    @(negedge clk);
    if (!rst_n) for (int f = 0; f < FLUX; f++) fires[f] = 0;
    exp_fire = 1'b0;
    exp_f = 0;
    for (int f = 0; f < FLUX; f++) begin
      if (!exp_fire && rst_n && pel_rd[f] != pel_wr[f] && del_rd[f] != del_wr[f] && !full_bits[f]) begin
        exp_fire = 1'b1;
        exp_f = f;
      end
    end
    exp_rd = '0;
    if (exp_fire) begin
      exp_rd[exp_f] = 1'b1;
      fv = exp_f;
      exp_q.push_back({fv[TW-1:0], model_value(exp_f)});
    end
    last_rd = pel_if.read;
    last_wr = res_if.write;
    check("pel_read", 64'(pel_if.read), 64'(exp_rd));
    check("del_read", 64'(del_if.read), 64'(exp_rd));
    check("write", 64'(res_if.write), 64'(exp_fire));
    if (res_if.write === 1'b1) begin
      got_q.push_back(res_if.din);
      if (exp_q.size() == 0) check("din_unexpected", 64'(res_if.din), 64'hx);
      else check("din", 64'(res_if.din), 64'(exp_q.pop_front()));
    end
    if (exp_fire) begin
      pel_rd[exp_f]++;
      del_rd[exp_f]++;
      fires[exp_f]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  function automatic logic [OW-1:0] pop_got();
    if (got_q.size() == 0) return 'x;
    return got_q.pop_front();
  endfunction

  initial begin
    for (int f = 0; f < FLUX; f++) begin
      pel_wr[f] = 0; pel_rd[f] = 0; del_wr[f] = 0; del_rd[f] = 0; fires[f] = 0;
      for (int i = 0; i < DEPTH; i++) begin pel_mem[f][i] = '0; del_mem[f][i] = '0; end
    end
    full_bits = '0;
    rst_n = 1'b0;
    drive();
    #1;
    // reset state: nothing read, nothing written
    check("reset_pel_read", 64'(pel_if.read), 64'd0);
    check("reset_write", 64'(res_if.write), 64'd0);
    do_reset();
    do_reset();

    // flux0: block start passthrough, then residual, then residual at cnt 2
    got_q.delete();
    push(0, 1, 18'd100, 1, 18'd0);
    push(0, 1, 18'd105, 1, 18'd100);
    push(0, 1, 18'd7, 1, 18'd3);
    repeat (4) cycle();
    check("t1_first", 64'(pop_got()), 64'({1'b0, 19'd100}));
    check("t1_second", 64'(pop_got()), 64'({1'b0, 19'd5}));
    check("t1_third_cnt2", 64'(pop_got()), 64'({1'b0, 19'd4}));

    // flux1: nine firings wrapping the block
    got_q.delete();
    for (int i = 0; i < 9; i++) push(1, 1, 18'd50, 1, 18'd60);
    repeat (10) cycle();
    check("t2_start", 64'(pop_got()), 64'({1'b1, 19'd50}));
    for (int i = 0; i < 7; i++) check("t2_neg10", 64'(pop_got()), 64'({1'b1, 19'h7FFF6}));
    check("t2_wrap", 64'(pop_got()), 64'({1'b1, 19'd50}));

    // both fluxes eligible: flux0 first, flux1 next cycle
    push(0, 1, 18'd10, 1, 18'd2);
    push(1, 1, 18'd20, 1, 18'd5);
    cycle();
    check("t3_first_grant", 64'(last_rd), 64'(2'b01));
    cycle();
    check("t3_second_grant", 64'(last_rd), 64'(2'b10));

    // back-pressure on flux0 only
    got_q.delete();
    full_bits = 2'b01;
    push(0, 1, 18'd30, 1, 18'd10);
    push(1, 1, 18'd40, 1, 18'd45);
    cycle();
    check("t4_flux1_passes", 64'(last_rd), 64'(2'b10));
    cycle();
    check("t4_flux0_held", 64'(last_rd), 64'(2'b00));
    full_bits = 2'b00;
    cycle();
    check("t4_flux0_resumes", 64'(last_rd), 64'(2'b01));
    void'(pop_got());
    check("t4_flux0_value", 64'(pop_got()), 64'({1'b0, 19'd20}));

    // missing delayed token: no read on either port
    push(0, 1, 18'd9, 0, 18'd0);
    cycle();
    check("t5_no_read", 64'(last_rd), 64'(2'b00));
    check("t5_no_write", 64'(last_wr), 64'd0);
    push(0, 0, 18'd0, 1, 18'd4);
    cycle();

    // extreme residual mid-block
    do_reset();
    got_q.delete();
    push(0, 1, 18'd500, 1, 18'd1);
    push(0, 1, 18'd0, 1, 18'd262143);
    repeat (3) cycle();
    check("t6_start", 64'(pop_got()), 64'({1'b0, 19'd500}));
`ifdef PEL_DELAY_SUB_SAT_EN
    check("t6_extreme", 64'(pop_got()), 64'({1'b0, 19'h60000}));
`else
    check("t6_extreme", 64'(pop_got()), 64'({1'b0, 19'h40001}));
`endif

    // reset mid-block, then a firing restarts the block
    push(0, 1, 18'd11, 1, 18'd1);
    cycle();
    got_q.delete();
    push(0, 1, 18'd1000, 1, 18'd999);
    do_reset();
    cycle();
    check("t7_reset_passthrough", 64'(pop_got()), 64'({1'b0, 19'd1000}));

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int f = 0; f < FLUX; f++) begin
        push(f, $urandom_range(0, 2) != 0, DW'($urandom), $urandom_range(0, 2) != 0, DW'($urandom));
      end
      full_bits = FLUX'($urandom_range(0, 3)) & FLUX'($urandom_range(0, 3));
      if ($urandom_range(0, 60) == 0) do_reset();
      else cycle();
    end
    full_bits = '0;
    // drain: cycles bounded, then every token must have been consumed in pairs
    for (int n = 0; n < 3000; n++) begin
      for (int f = 0; f < FLUX; f++) begin
        if (pel_wr[f] - pel_rd[f] < del_wr[f] - del_rd[f]) push(f, 1, DW'($urandom), 0, '0);
        if (del_wr[f] - del_rd[f] < pel_wr[f] - pel_rd[f]) push(f, 0, '0, 1, DW'($urandom));
      end
      cycle();
      if (pel_rd[0] == pel_wr[0] && pel_rd[1] == pel_wr[1]) break;
    end
    check("drain_flux0", 64'(pel_wr[0] - pel_rd[0]), 64'd0);
    check("drain_flux1", 64'(pel_wr[1] - pel_rd[1]), 64'd0);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
